booth_accumulator: RTL

Signed accumulator that sits directly downstream of the Booth multiplier. It sums a programmed number of 2N-bit signed products into a wider accumulator, which makes the multiplier the inner step of a dot-product / MAC datapath. A valid/ready handshake lets the multiplier's completion (its DONE state) act as `prod_valid`. The block reports the final sum with a one-cycle `done` pulse.

---
 rtl/booth_pkg.sv | 27 ++
 rtl/booth_accumulator_sat_add.sv | 28 ++
 rtl/booth_accumulator.sv | 103 ++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier / accumulator datapath.
// Holds the accumulator FSM encoding, default widths and a sign-extend helper.
package booth_pkg;

  localparam int N_DEF       = 4;
  localparam int LEN_MAX_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  // Replicate bit w-1 into all higher bits of a 64-bit container.
  function automatic logic [63:0] sext(
    input logic [63:0] x,
    input int          w
  );
    logic [63:0] r;
    r = x;
    for (int i = 0; i < 64; i++) begin
      if (i >= w) r[i] = x[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_accumulator_sat_add.sv
// W-bit two's complement adder with signed overflow flag.
// Ports: a, b in; sum, ovf out. Clamps on overflow with BOOTH_ACC_SAT_EN.
module sat_add #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] raw;

  assign raw = a + b;
  // Same-sign operands whose result flips sign.
  assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef BOOTH_ACC_SAT_EN
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  // Direction of overflow follows the shared operand sign.
  assign sum = ovf ? (a[W-1] ? MINV : MAXV) : raw;
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/booth_accumulator.sv
// Sums len signed 2N-bit products into an ACC_W accumulator, pulses done.
// Ports: clk, rst(async low), start, len, prod_valid/prod/prod_ready, acc, busy, done, ovf. Option: BOOTH_ACC_SAT_EN.
module booth_accumulator
  import booth_pkg::*;
#(
  parameter  int N       = N_DEF,
  parameter  int LEN_MAX = LEN_MAX_DEF,
  parameter  int ACC_W   = 2*N + $clog2(LEN_MAX),
  localparam int LW      = $clog2(LEN_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LW-1:0]    len,
  input  logic             prod_valid,
  input  logic [2*N-1:0]   prod,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  acc_state_t       state;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    len_sat;
  logic [LW-1:0]    cnt;
  logic [LW-1:0]    cnt_nxt;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic             accept;

  assign len_sat  = (len > LW'(LEN_MAX)) ? LW'(LEN_MAX) : len;
  assign cnt_nxt  = cnt + LW'(1);
  assign accept   = prod_valid && prod_ready;
  assign prod_ext = ACC_W'(sext(64'(prod), 2*N));

  sat_add #(
    .W(ACC_W)
  ) u_add (
    .a  (acc),
    .b  (prod_ext),
    .sum(sum),
    .ovf(add_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      len_q      <= '0;
      cnt        <= '0;
      acc        <= '0;
      prod_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc  <= '0;
            ovf  <= 1'b0;
            cnt  <= '0;
            busy <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= ACCUM;
              len_q      <= len_sat;
              prod_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= sum;
            ovf <= ovf | add_ovf;
            cnt <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              state      <= DONE;
              prod_ready <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          prod_ready <= 1'b0;
          done       <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
